// File: rtl/wb_pipeline_slave_if.sv
// Wishbone B4 pipelined bus bundle between one master and the wb_pipeline_slave responder.
// Latency: none, this is wiring only; timing is set by the endpoints.
// Backpressure: wb_stall_o flows slave->master and holds the master's request in place.
interface wb_pipeline_slave_if #(
   parameter int WB_BUS_WIDTH  = 16,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int TAG_WIDTH     = 4
);
   localparam int WB_SEL_WIDTH = WB_BUS_WIDTH / 8;

   // Request channel (master -> slave)
   logic                     wb_cyc_i;
   logic                     wb_stb_i;
   logic                     wb_we_i;
   logic [WB_ADDR_WIDTH-1:0] wb_addr_i;
   logic [WB_SEL_WIDTH-1:0]  wb_sel_i;
   logic [WB_BUS_WIDTH-1:0]  wb_data_i;
   logic [TAG_WIDTH-1:0]     wb_tga_i;

   // Response channel (slave -> master)
   logic [WB_BUS_WIDTH-1:0]  wb_data_o;
   logic [TAG_WIDTH-1:0]     wb_tgd_o;
   logic                     wb_ack_o;
   logic                     wb_err_o;
   logic                     wb_rty_o;
   logic                     wb_stall_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i, wb_tga_i,
      output wb_data_o, wb_tgd_o, wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i, wb_tga_i,
      input  wb_data_o, wb_tgd_o, wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o
   );
endinterface

// File: rtl/wb_pipeline_slave.sv
// Pipelined Wishbone B4 slave fronting a local single-port, byte-lane-writable word memory.
// Latency: every ack/err leaves exactly READ_LATENCY cycles after acceptance, strictly in order.
// Backpressure: wb_stall_o asserts while MAX_OUTSTANDING responses are pending and none leaves this cycle.
module wb_pipeline_slave #(
   parameter int                       WB_BUS_WIDTH    = 16,
   parameter int                       WB_ADDR_WIDTH   = 32,
   parameter int                       TAG_WIDTH       = 4,
   parameter int                       MEM_DEPTH_LOG2  = 8,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                       READ_LATENCY    = 3,
   parameter int                       MAX_OUTSTANDING = 2
) (
   input  logic               wb_clk_i,
   input  logic               wb_reset_i,
   wb_pipeline_slave_if.slave bus
);
   localparam int WB_SEL_WIDTH = WB_BUS_WIDTH / 8;
   localparam int MEM_DEPTH    = 1 << MEM_DEPTH_LOG2;
   localparam int CNT_W        = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   // One response slot travelling down the latency pipeline (valid kept separately).
   typedef struct packed {
      logic                    is_err;
      logic                    is_read;
      logic [TAG_WIDTH-1:0]    tag;
      logic [WB_BUS_WIDTH-1:0] data;
   } resp_t;

   logic [WB_BUS_WIDTH-1:0]  r_mem [MEM_DEPTH];
   logic [READ_LATENCY-1:0]  r_vld;
   resp_t                    r_resp [READ_LATENCY];
   logic [CNT_W-1:0]         r_count;

   logic [WB_ADDR_WIDTH-1:0] w_off;
   logic [MEM_DEPTH_LOG2-1:0] w_idx;
   logic                     w_in_range;
   logic                     w_accept;
   logic                     w_resp_out;
   logic                     w_stall;
   logic                     w_ack;
   logic                     w_err;
   resp_t                    w_new;
   resp_t                    w_last;

   // Decode: unsigned offset from the window base; an address below the base would wrap
   // to a huge offset, so the explicit >= test keeps that from aliasing into the window.
   assign w_off      = bus.wb_addr_i - BASE_ADDR;
   assign w_idx      = w_off[MEM_DEPTH_LOG2-1:0];
   assign w_in_range = (bus.wb_addr_i >= BASE_ADDR) &&
                       (w_off[WB_ADDR_WIDTH-1:MEM_DEPTH_LOG2] == '0);

   // A response leaving this cycle frees a slot, so the stall can drop in the same cycle.
   assign w_resp_out = r_vld[READ_LATENCY-1];
   assign w_stall    = (r_count == CNT_MAX) && !w_resp_out;
   assign w_accept   = bus.wb_cyc_i && bus.wb_stb_i && !w_stall;

   // Response captured at acceptance; memory is read here so a read right after a write
   // to the same word already sees the committed bytes.
   assign w_new.is_err  = !w_in_range;
   assign w_new.is_read = !bus.wb_we_i;
   assign w_new.tag     = bus.wb_tga_i;
   assign w_new.data    = (w_in_range && !bus.wb_we_i) ? r_mem[w_idx] : '0;

   // Byte-lane write at the acceptance edge; contents deliberately survive reset and abort.
   always_ff @(posedge wb_clk_i) begin
      if (w_accept && w_in_range && bus.wb_we_i) begin
         for (int b = 0; b < WB_SEL_WIDTH; b++) begin
            if (bus.wb_sel_i[b]) begin
               r_mem[w_idx][8*b +: 8] <= bus.wb_data_i[8*b +: 8];
            end
         end
      end
   end

   // Fixed-depth response shift register; dropping wb_cyc_i discards everything in flight.
   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) begin
         r_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_resp[i] <= '0;
         end
      end else if (!bus.wb_cyc_i) begin
         r_vld <= '0;
      end else begin
         r_vld[0]  <= w_accept;
         r_resp[0] <= w_new;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_resp[i] <= r_resp[i-1];
         end
      end
   end

   // Outstanding count: accept and retire in the same cycle cancel out.
   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) begin
         r_count <= '0;
      end else if (!bus.wb_cyc_i) begin
         r_count <= '0;
      end else if (w_accept && !w_resp_out) begin
         r_count <= r_count + CNT_W'(1);
      end else if (!w_accept && w_resp_out) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   // Terminations are gated by wb_cyc_i so an abort cycle never shows a stray ack/err.
   assign w_last         = r_resp[READ_LATENCY-1];
   assign w_ack          = w_resp_out && !w_last.is_err && bus.wb_cyc_i;
   assign w_err          = w_resp_out &&  w_last.is_err && bus.wb_cyc_i;

   assign bus.wb_ack_o   = w_ack;
   assign bus.wb_err_o   = w_err;
   assign bus.wb_rty_o   = 1'b0;
   assign bus.wb_stall_o = w_stall;
   assign bus.wb_data_o  = (w_ack && w_last.is_read) ? w_last.data : '0;
   assign bus.wb_tgd_o   = (w_ack || w_err) ? w_last.tag : '0;
endmodule
